// File: rtl/uart_tx_ctrl_pkg.sv
// uart_tx_ctrl_pkg: shared types and defaults
// for the UART transmit sequencer.
package uart_tx_ctrl_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;
  localparam int UART_STOP_BITS    = 1;

  // Counter width for values 0..n-1, never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uartTxState_t;

  typedef logic [cnt_w(UART_CLKS_PER_BIT)-1:0] uartBaudCount_t;
  typedef logic [UART_DATA_BITS-1:0] uartTxData_t;

endpackage

// File: rtl/uart_tx_ctrl_baud_tick.sv
// uart_baud_tick: bit-period timer, wraps
// every CLKS_PER_BIT cycles and flags the last one.
module uart_baud_tick
  import uart_tx_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = !clear && (cnt_q == LAST);

  // Count up, wrap on the tick, hold at 0 while cleared.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || bit_tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frames one word per handshake
// into start/data/parity/stop on the tx line.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = UART_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BW   = cnt_w(BMAX);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uartTxState_t         state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 tx_q, tx_d;

  logic bit_tick;
  logic accept;
  logic last_tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .bit_tick(bit_tick)
  );

  // The final stop tick frees the controller in the same
  // cycle, so a waiting word starts with no idle gap.
  assign last_tick = (state_q == STOP) && bit_tick &&
                     (bit_q == LAST_STOP);
  assign accept    = tx_valid && tx_ready;

  // State, shifter, counters and line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Next state and next line level per phase.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = tx_data;
          par_d   = ^tx_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_q == LAST_STOP) begin
            bit_d = '0;
            if (accept) begin
              state_d = START;
              shift_d = tx_data;
              par_d   = ^tx_data;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    tx_ready = (state_q == IDLE) || last_tick;
    busy     = !tx_ready;
    tx_done  = last_tick;
    tx       = tx_q;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench, three
// parameter sets sharing one clock.
module tb_uart_tx_ctrl;

  typedef struct packed {
    logic [1:0] dut;
    logic       tx;
    logic       done;
  } exp_t;

  localparam int CPB [3] = '{4, 4, 1};
  localparam int PAR [3] = '{0, 1, 0};
  localparam int SB  [3] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_r  [3];
  logic       valid_r [3];
  logic       tx_w    [3];
  logic       rdy_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_last [3];
  int   done_gap  [3];
  exp_t sb [$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_ctrl #(
    .DATA_BITS(8), .CLKS_PER_BIT(4),
    .PARITY_EN(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .reset(rst),
    .tx_data(data_r[0]), .tx_valid(valid_r[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]),
    .busy(busy_w[0]), .tx_done(done_w[0])
  );

  uart_tx_ctrl #(
    .DATA_BITS(8), .CLKS_PER_BIT(4),
    .PARITY_EN(1), .STOP_BITS(1)
  ) u_b (
    .clk(clk), .reset(rst),
    .tx_data(data_r[1]), .tx_valid(valid_r[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]),
    .busy(busy_w[1]), .tx_done(done_w[1])
  );

  uart_tx_ctrl #(
    .DATA_BITS(8), .CLKS_PER_BIT(1),
    .PARITY_EN(0), .STOP_BITS(2)
  ) u_c (
    .clk(clk), .reset(rst),
    .tx_data(data_r[2]), .tx_valid(valid_r[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]),
    .busy(busy_w[2]), .tx_done(done_w[2])
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Monitor: every in-frame cycle pops one expected level.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (!rdy_w[d] || done_w[d]) begin
          if (sb.size() == 0 || int'(sb[0].dut) != d) begin
            checks++;
            errors++;
            $display("FAIL dut%0d frame: got frame cycle tx=%0b required none",
                     d, tx_w[d]);
          end else begin
            mon_e = sb.pop_front();
            chk($sformatf("dut%0d tx @%0d", d, cyc), tx_w[d], mon_e.tx);
            chk($sformatf("dut%0d done @%0d", d, cyc), done_w[d], mon_e.done);
            chk($sformatf("dut%0d busy @%0d", d, cyc), busy_w[d], !mon_e.done);
          end
          if (done_w[d]) begin
            done_gap[d]  = cyc - done_last[d];
            done_last[d] = cyc;
          end
        end else begin
          chk($sformatf("dut%0d idle tx @%0d", d, cyc), tx_w[d], 1);
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input int d, input logic [7:0] v,
                            input logic p);
    logic lv [$];
    exp_t e;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(v[i]);
    if (PAR[d] != 0) lv.push_back(p);
    for (int i = 0; i < SB[d]; i++) lv.push_back(1'b1);
    for (int i = 0; i < lv.size(); i++) begin
      for (int c = 0; c < CPB[d]; c++) begin
        e.dut  = 2'(d);
        e.tx   = lv[i];
        e.done = (i == lv.size() - 1) && (c == CPB[d] - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send(input int d, input logic [7:0] v,
                      input logic p, input bit hold);
    int n;
    n = 0;
    data_r[d]  = v;
    valid_r[d] = 1'b1;
    while (!rdy_w[d] && n < 200) begin
      tick();
      n++;
    end
    if (!rdy_w[d]) begin
      checks++;
      errors++;
      $display("FAIL dut%0d accept: tx_ready got 0 required 1", d);
      valid_r[d] = 1'b0;
      return;
    end
    push_frame(d, v, p);
    tick();
    if (!hold) valid_r[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((sb.size() != 0 || !rdy_w[d] || done_w[d]) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || !rdy_w[d]) begin
      errors++;
      $display("FAIL dut%0d idle: pending got %0d required 0", d, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      valid_r[d]   = 1'b0;
      data_r[d]    = 8'h00;
      done_last[d] = 0;
      done_gap[d]  = 0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d reset tx", d), tx_w[d], 1);
      chk($sformatf("dut%0d reset ready", d), rdy_w[d], 1);
      chk($sformatf("dut%0d reset busy", d), busy_w[d], 0);
      chk($sformatf("dut%0d reset done", d), done_w[d], 0);
    end
    rst = 1'b0;
    tick();

    send(0, 8'hA5, 1'b0, 1'b0);
    wait_idle(0);

    send(1, 8'h07, 1'b1, 1'b0);
    wait_idle(1);
    send(1, 8'h03, 1'b0, 1'b0);
    wait_idle(1);

    send(0, 8'h55, 1'b0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b0);
    wait_idle(0);
    chk("b2b done gap", done_gap[0], 40);

    send(0, 8'h3C, 1'b0, 1'b0);
    repeat (12) tick();
    data_r[0]  = 8'h99;
    valid_r[0] = 1'b1;
    chk("busy ignores valid", rdy_w[0], 0);
    tick();
    valid_r[0] = 1'b0;
    wait_idle(0);

    send(0, 8'h5A, 1'b0, 1'b0);
    repeat (13) tick();
    rst = 1'b1;
    tick();
    chk("abort tx", tx_w[0], 1);
    chk("abort ready", rdy_w[0], 1);
    chk("abort busy", busy_w[0], 0);
    chk("abort done", done_w[0], 0);
    sb.delete();
    rst = 1'b0;
    tick();
    send(0, 8'hC3, 1'b0, 1'b0);
    wait_idle(0);

    send(2, 8'h80, 1'b0, 1'b0);
    wait_idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
